mem_arbiter_rr: RTL and testbench

Parametrised round-robin arbiter between N cache-side physical-memory requesters and a single cacheline adaptor. It generalises the fixed two-port instruction/data arbiter to `NUM_PORTS` requesters with configurable line and address width. It adds fair rotating priority, a bounded wait for every requester, and registered outputs on both sides. It sits between the per-requester caches (I-cache, D-cache, later prefetcher or L2 ports) and `cacheline_adaptor`.

---
 rtl/mem_arbiter_rr.sv | 104 ++++++++++
 tb/tb_mem_arbiter_rr.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that funnels NUM_PORTS cache-side memory requesters into one cacheline adaptor.
// All outputs are registered; one transaction is in flight at a time.
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [LINE_W-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [ADDR_W-1:0]           pmem_address,
    output logic [LINE_W-1:0]           pmem_wdata,
    output logic                        pmem_read,
    output logic                        pmem_write,
    input  logic [LINE_W-1:0]           pmem_rdata,
    input  logic                        pmem_resp,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     gnt;
    logic [IDX_W-1:0]     pick;
    logic                 any_req;
    logic [NUM_PORTS-1:0] requesting;

    assign requesting = req_read | req_write;
    assign busy       = (state != IDLE);

    // Scan from the farthest offset back to ptr so the closest requester to ptr wins.
    always_comb begin
        int j;
        pick    = ptr;
        any_req = 1'b0;
        j       = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (requesting[IDX_W'(j)]) begin
                pick    = IDX_W'(j);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            req_resp     <= '0;
            req_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt          <= pick;
                        pmem_address <= req_address[int'(pick)*ADDR_W +: ADDR_W];
                        pmem_wdata   <= req_wdata[int'(pick)*LINE_W +: LINE_W];
                        // A port asserting both read and write is treated as a write.
                        pmem_write   <= req_write[pick];
                        pmem_read    <= req_read[pick] & ~req_write[pick];
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        req_rdata  <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        req_resp   <= NUM_PORTS'(1) << gnt;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_resp <= '0;
                    ptr      <= (gnt == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with four requesters and the adaptor modelled by hand.
module tb_mem_arbiter_rr;

    localparam int NP = 4;
    localparam int LW = 256;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  req_address;
    logic [NP-1:0]     req_read;
    logic [NP-1:0]     req_write;
    logic [NP*LW-1:0]  req_wdata;
    logic [LW-1:0]     req_rdata;
    logic [NP-1:0]     req_resp;
    logic [AW-1:0]     pmem_address;
    logic [LW-1:0]     pmem_wdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [LW-1:0]     pmem_rdata;
    logic              pmem_resp;
    logic              busy;

    int check_count = 0;
    int pass_count  = 0;

    mem_arbiter_rr #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Advance one rising edge and park on the falling edge for sampling and driving.
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int p, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [LW-1:0] data);
        req_read[p]              = rd;
        req_write[p]             = wr;
        req_address[p*AW +: AW]  = addr;
        req_wdata[p*LW +: LW]    = data;
    endtask

    task automatic doReset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // One read transaction granted at the next edge, adaptor answering at k=2.
    task automatic runTxn(input string tag, input int p, input logic [AW-1:0] addr,
                          input logic [LW-1:0] line, input bit drop);
        logic [NP-1:0] onehot;
        onehot    = '0;
        onehot[p] = 1'b1;
        tick;
        checkOutput({tag, "_addr"}, LW'(pmem_address), LW'(addr));
        checkOutput({tag, "_read"}, LW'(pmem_read), LW'(1));
        tick;
        pmem_resp  = 1'b1;
        pmem_rdata = line;
        tick;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        checkOutput({tag, "_resp"}, LW'(req_resp), LW'(onehot));
        checkOutput({tag, "_rdata"}, req_rdata, line);
        if (drop) applyStimulus(p, 1'b0, 1'b0, addr, '0);
        tick;
        checkOutput({tag, "_idle"}, LW'({busy, req_resp}), LW'(0));
    endtask

    logic [LW-1:0] wline;
    logic [LW-1:0] a5line;

    initial begin
        req_address = '0;
        req_read    = '0;
        req_write   = '0;
        req_wdata   = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        rst         = 1'b1;
        a5line      = {32{8'hA5}};
        wline       = '0;
        for (int i = 0; i < 8; i++) wline[i*32 +: 32] = 32'h1234_5678 ^ 32'(i);

        // Reset values, with a request held high to show reset dominates.
        req_read = '1;
        tick;
        tick;
        checkOutput("rst_read",  LW'(pmem_read), LW'(0));
        checkOutput("rst_write", LW'(pmem_write), LW'(0));
        checkOutput("rst_addr",  LW'(pmem_address), LW'(0));
        checkOutput("rst_wdata", pmem_wdata, LW'(0));
        checkOutput("rst_resp",  LW'(req_resp), LW'(0));
        checkOutput("rst_rdata", req_rdata, LW'(0));
        checkOutput("rst_busy",  LW'(busy), LW'(0));
        checkOutput("rst_ptr",   LW'(dut.ptr), LW'(0));
        req_read = '0;
        rst      = 1'b0;

        // Single read from the last port, adaptor latency k=4; ptr must wrap to 0.
        applyStimulus(3, 1'b1, 1'b0, 32'h0000_1000, '0);
        for (int c = 1; c <= 4; c++) begin
            tick;
            checkOutput($sformatf("single_rd_c%0d", c), LW'(pmem_read), LW'(1));
            if (c == 1) checkOutput("single_addr", LW'(pmem_address), LW'(32'h0000_1000));
            if (c == 4) begin
                pmem_resp  = 1'b1;
                pmem_rdata = a5line;
            end
        end
        tick;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        checkOutput("single_resp",  LW'(req_resp), LW'(4'b1000));
        checkOutput("single_rdata", req_rdata, a5line);
        checkOutput("single_rd_c5", LW'(pmem_read), LW'(0));
        checkOutput("single_busy5", LW'(busy), LW'(1));
        applyStimulus(3, 1'b0, 1'b0, 32'h0000_1000, '0);
        tick;
        checkOutput("single_resp6", LW'(req_resp), LW'(0));
        checkOutput("single_busy6", LW'(busy), LW'(0));
        checkOutput("single_ptr",   LW'(dut.ptr), LW'(0));

        // All four ports request continuously from reset: grants 0,1,2,3,0.
        doReset();
        for (int p = 0; p < NP; p++) applyStimulus(p, 1'b1, 1'b0, 32'h1000_0000 + 32'(p*64), '0);
        runTxn("rr0", 0, 32'h1000_0000, {8{32'hC0DE_0000}}, 1'b0);
        runTxn("rr1", 1, 32'h1000_0040, {8{32'hC0DE_0001}}, 1'b0);
        runTxn("rr2", 2, 32'h1000_0080, {8{32'hC0DE_0002}}, 1'b0);
        runTxn("rr3", 3, 32'h1000_00C0, {8{32'hC0DE_0003}}, 1'b0);
        runTxn("rr4", 0, 32'h1000_0000, {8{32'hC0DE_0004}}, 1'b0);
        for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 1'b0, '0, '0);

        // Write from port 0 with its inputs disturbed mid-BUSY.
        applyStimulus(0, 1'b0, 1'b1, 32'hDEAD_BEE0, wline);
        for (int c = 1; c <= 3; c++) begin
            tick;
            checkOutput($sformatf("wr_write_c%0d", c), LW'(pmem_write), LW'(1));
            checkOutput($sformatf("wr_read_c%0d", c),  LW'(pmem_read), LW'(0));
            checkOutput($sformatf("wr_addr_c%0d", c),  LW'(pmem_address), LW'(32'hDEAD_BEE0));
            checkOutput($sformatf("wr_wdata_c%0d", c), pmem_wdata, wline);
            if (c == 1) applyStimulus(0, 1'b0, 1'b1, 32'h1111_2220, ~wline);
            if (c == 3) pmem_resp = 1'b1;
        end
        tick;
        pmem_resp = 1'b0;
        checkOutput("wr_resp",      LW'(req_resp), LW'(4'b0001));
        checkOutput("wr_write_end", LW'(pmem_write), LW'(0));
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        tick;

        // Spurious adaptor response while idle.
        pmem_resp  = 1'b1;
        pmem_rdata = a5line;
        for (int c = 1; c <= 2; c++) begin
            tick;
            checkOutput($sformatf("spur_busy_c%0d", c), LW'(busy), LW'(0));
            checkOutput($sformatf("spur_resp_c%0d", c), LW'(req_resp), LW'(0));
            checkOutput($sformatf("spur_rd_c%0d", c),   LW'({pmem_read, pmem_write}), LW'(0));
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;

        // Reset at cycle 2 of a read, with an adaptor response racing it.
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_2000, '0);
        tick;
        checkOutput("abort_busy1", LW'(busy), LW'(1));
        tick;
        rst       = 1'b1;
        pmem_resp = 1'b1;
        tick;
        checkOutput("abort_busy",  LW'(busy), LW'(0));
        checkOutput("abort_read",  LW'(pmem_read), LW'(0));
        checkOutput("abort_addr",  LW'(pmem_address), LW'(0));
        checkOutput("abort_resp",  LW'(req_resp), LW'(0));
        checkOutput("abort_ptr",   LW'(dut.ptr), LW'(0));
        rst       = 1'b0;
        pmem_resp = 1'b0;
        applyStimulus(2, 1'b0, 1'b0, '0, '0);
        tick;
        checkOutput("abort_resp2", LW'(req_resp), LW'(0));

        // Port 0 requests back to back; port 2 must get the very next grant.
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_3000, '0);
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_3080, '0);
        runTxn("starve0", 0, 32'h0000_3000, {8{32'hBEEF_0000}}, 1'b0);
        runTxn("starve1", 2, 32'h0000_3080, {8{32'hBEEF_0002}}, 1'b1);
        runTxn("starve2", 0, 32'h0000_3000, {8{32'hBEEF_0010}}, 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
